melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Plays a programmable melody by sequencing the note_div input of the buzzer/speaker datapath.
- Holds a 16-entry song RAM of {duration, note} entries and steps through them at a fixed tempo.
- Inserts a short silent articulation gap between notes; supports start, stop and loop.
- Sits between a control source (keypad/FSM) and buzzer_control; it replaces the free-running counter and sound-lookup path.

Parameters:
- BEAT_DIV, 5000000: clk cycles per duration unit (125 ms at 40 MHz).
- GAP_CYCLES, 400000: silent cycles at the end of every note. Must be less than BEAT_DIV.

Ports:
- clk  input  1  system clock (40 MHz crystal)
- rst_n  input  1  synchronous, active-high reset (1 = reset)
- start  input  1  1-cycle pulse: begin playback at entry 0
- stop  input  1  1-cycle pulse: abort playback
- loop_en  input  1  level: wrap to entry 0 after the last entry
- last_idx  input  4  index of the final song entry; latched on start
- wr_en  input  1  song RAM write strobe
- wr_addr  input  4  song RAM write address
- wr_data  input  8  {dur[7:4], note[3:0]}
- note_div  output  20  period divider to buzzer_control; 0 = silent
- mute  output  1  1 when no tone is playing
- busy  output  1  1 in any state other than IDLE
- note_idx  output  4  index of the entry currently playing
- done  output  1  1-cycle pulse when a non-looping song ends

Behaviour:
- Reset: state IDLE; note_div=0, mute=1, busy=0, note_idx=0, done=0. The song RAM is NOT reset, so its contents survive reset.
- FSM states: IDLE, LOAD, NOTE, GAP. All outputs are registered.
- IDLE -> LOAD on start. On that edge: latch last_idx, set idx=0.
- LOAD (1 cycle):
  - Read RAM[idx].
  - Note length = D*BEAT_DIV - GAP_CYCLES cycles, where D = dur, or 16 when dur=0.
  - Go to NOTE.
  - note_div/mute become valid in the first NOTE cycle, i.e. 2 cycles after the start pulse.
- NOTE:
  - Hold note_div from the note map.
  - Leave for GAP after the computed cycle count; the NOTE state occupies exactly that many cycles.
- GAP:
  - note_div=0, mute=1 for exactly GAP_CYCLES cycles.
  - Then, if idx != latched last_idx: idx+1, go to LOAD.
  - Else if loop_en (sampled in the final GAP cycle): idx=0, go to LOAD.
  - Else go to IDLE and pulse done for 1 cycle.
- Note map (full period in clk cycles):
  - note 1..7 = C4..B4 = 152905, 136240, 121359, 114548, 102041, 90909, 80972.
  - note 8..14 = the note (code-7) value >>1, i.e. one octave up.
  - note 0 and 15 = rest: note_div=0, mute=1 for the whole NOTE time.
- Per-note timing: one note occupies 1 (LOAD) + D*BEAT_DIV cycles in total.
- Counters: duration count uses a 27-bit counter (worst case 16*BEAT_DIV). idx wraps 15 -> 0 naturally.
- stop: from any non-IDLE state, go to IDLE next cycle. Outputs return to reset values; done is NOT pulsed.
- start while busy: restart from entry 0 through LOAD, and re-latch last_idx.
- start and stop in the same cycle: stop wins.
- Writes:
  - Allowed at any time.
  - A write to the entry being read in LOAD returns the old data (read-before-write).
  - A write to a later entry takes effect when that entry is loaded.
- Reset mid-playback: immediate return to the reset state on the next edge.
- note_idx: equals idx in LOAD/NOTE/GAP; 0 in IDLE.

Test Plan:
All directed tests use BEAT_DIV=10 and GAP_CYCLES=2.

1. Single entry:
   - Stimulus: RAM[0]=0x21, last_idx=0, start.
   - Required: note_div=152905 from cycle 2 for 18 cycles, then 0 for 2 cycles, then done pulse and busy=0.
2. Sequence with rest and octave:
   - Stimulus: RAM[0..2]=0x11, 0x10, 0x18, last_idx=2.
   - Required: note_div sequence 152905 (8 cycles), 0 (mute=1 for the whole rest), 76452.
   - Required: note_idx steps 0, 1, 2.
3. Loop:
   - Stimulus: loop_en=1, last_idx=1.
   - Required: after entry 1's gap, LOAD of idx 0; no done pulse.
   - Then deassert loop_en. Required: done pulses after the next entry-1 gap.
4. Stop and collision:
   - Stimulus: stop mid-NOTE.
   - Required: next cycle note_div=0, mute=1, busy=0, no done pulse.
   - Stimulus: start and stop in the same cycle. Required: stays IDLE.
5. Zero duration, restart and write-during-load:
   - Stimulus: dur=0 entry. Required: NOTE lasts 158 cycles.
   - Stimulus: start while busy. Required: replays from entry 0.
   - Stimulus: write RAM[0] during its LOAD. Required: old note plays.
6. Reset:
   - Stimulus: assert rst_n=1 mid-GAP.
   - Required: all outputs return to reset values next edge.
   - Stimulus: start again. Required: the previously written RAM contents play unchanged.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a 16-entry {duration, note} song RAM and drives the
// buzzer period divider, with a silent articulation gap at the end of each note.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | not playing, outputs silent
// S_LOAD | one cycle: read RAM[idx], compute note length
// S_NOTE | tone (or rest) held for D*BEAT_DIV - GAP_CYCLES cycles
// S_GAP  | silent for GAP_CYCLES cycles, then advance / loop / finish
module melody_sequencer #(
    parameter int BEAT_DIV   = 5000000,
    parameter int GAP_CYCLES = 400000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        loop_en,
    input  logic [3:0]  last_idx,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [19:0] note_div,
    output logic        mute,
    output logic        busy,
    output logic [3:0]  note_idx,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_NOTE, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  last_q, last_d;
    logic [26:0] cnt_q, cnt_d;
    logic [3:0]  note_q, note_d;
    logic [19:0] note_div_q, note_div_d;
    logic        mute_q, mute_d;
    logic        busy_q, busy_d;
    logic [3:0]  note_idx_q, note_idx_d;
    logic        done_q, done_d;

    logic [7:0]  ram_q [16];
    logic [7:0]  rd_data;
    logic [4:0]  dur_units;
    logic [26:0] note_len;

    // Full tone period for a note code; codes 8..14 are the 1..7 tones an octave up.
    function automatic logic [19:0] note_period(input logic [3:0] code);
        logic [3:0]  base_code;
        logic [19:0] base;
        base_code = (code >= 4'd8) ? code - 4'd7 : code;
        case (base_code)
            4'd1:    base = 20'd152905;
            4'd2:    base = 20'd136240;
            4'd3:    base = 20'd121359;
            4'd4:    base = 20'd114548;
            4'd5:    base = 20'd102041;
            4'd6:    base = 20'd90909;
            4'd7:    base = 20'd80972;
            default: base = 20'd0;
        endcase
        if (code == 4'd0 || code == 4'd15) begin
            note_period = 20'd0;
        end else if (code >= 4'd8) begin
            note_period = base >> 1;
        end else begin
            note_period = base;
        end
    endfunction

    // Song RAM write port; deliberately unreset so a song survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram_q[wr_addr] <= wr_data;
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        note_d    = note_q;
        done_d    = 1'b0;
        rd_data   = ram_q[idx_q];
        dur_units = (rd_data[7:4] == 4'd0) ? 5'd16 : {1'b0, rd_data[7:4]};
        note_len  = 27'(dur_units * BEAT_DIV) - 27'(GAP_CYCLES);

        if (stop) begin
            state_d = S_IDLE;
        end else if (start) begin
            state_d = S_LOAD;
            idx_d   = 4'd0;
            last_d  = last_idx;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_LOAD: begin
                    note_d  = rd_data[3:0];
                    cnt_d   = note_len - 27'd1;
                    state_d = S_NOTE;
                end
                S_NOTE: begin
                    if (cnt_q == 27'd0) begin
                        cnt_d   = 27'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q - 27'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == 27'd0) begin
                        if (idx_q != last_q) begin
                            idx_d   = idx_q + 4'd1;
                            state_d = S_LOAD;
                        end else if (loop_en) begin
                            idx_d   = 4'd0;
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 27'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are derived from the next state so they are valid in the cycle they describe.
        note_div_d = (state_d == S_NOTE) ? note_period(note_d) : 20'd0;
        mute_d     = (note_div_d == 20'd0);
        busy_d     = (state_d != S_IDLE);
        note_idx_d = (state_d == S_IDLE) ? 4'd0 : idx_d;
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= 4'd0;
            last_q     <= 4'd0;
            cnt_q      <= 27'd0;
            note_q     <= 4'd0;
            note_div_q <= 20'd0;
            mute_q     <= 1'b1;
            busy_q     <= 1'b0;
            note_idx_q <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            note_q     <= note_d;
            note_div_q <= note_div_d;
            mute_q     <= mute_d;
            busy_q     <= busy_d;
            note_idx_q <= note_idx_d;
            done_q     <= done_d;
        end
    end

    assign note_div = note_div_q;
    assign mute     = mute_q;
    assign busy     = busy_q;
    assign note_idx = note_idx_q;
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with BEAT_DIV=10, GAP_CYCLES=2.
module tb_melody_sequencer;

    localparam int BD = 10;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop_en, wr_en;
    logic [3:0]  last_idx, wr_addr;
    logic [7:0]  wr_data;
    logic [19:0] note_div;
    logic        mute, busy, done;
    logic [3:0]  note_idx;

    int n_cmp = 0;
    int n_bad = 0;

    melody_sequencer #(.BEAT_DIV(BD), .GAP_CYCLES(GC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .last_idx (last_idx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .note_div (note_div),
        .mute     (mute),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of outputs while done is expected low.
    task automatic cyc(input string tag, input int div, input int idx, input int bsy);
        chk({tag, "_div"},  32'(note_div), 32'(div));
        chk({tag, "_mute"}, 32'(mute),     (div == 0) ? 32'd1 : 32'd0);
        chk({tag, "_idx"},  32'(note_idx), 32'(idx));
        chk({tag, "_busy"}, 32'(busy),     32'(bsy));
        chk({tag, "_done"}, 32'(done),     32'd0);
    endtask

    task automatic write_ram(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic launch(input logic [3:0] last);
        last_idx = last; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Called in the LOAD cycle; returns in the cycle after the gap.
    task automatic play_entry(input string tag, input int div, input int idx, input int nlen);
        cyc({tag, "_load"}, 0, idx, 1);
        step();
        wr_en = 1'b0;
        for (int i = 0; i < nlen; i++) begin
            cyc({tag, "_note"}, div, idx, 1);
            step();
        end
        for (int i = 0; i < GC; i++) begin
            cyc({tag, "_gap"}, 0, idx, 1);
            step();
        end
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"},  32'(done),     32'd1);
        chk({tag, "_busy"},  32'(busy),     32'd0);
        chk({tag, "_div"},   32'(note_div), 32'd0);
        chk({tag, "_mute"},  32'(mute),     32'd1);
        chk({tag, "_idx"},   32'(note_idx), 32'd0);
        step();
        chk({tag, "_pulse"}, 32'(done),     32'd0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; last_idx = 4'd0;
        step();
        step();
        cyc("reset", 0, 0, 0);
        rst_n = 1'b0;
        step();

        // 1: single entry, D=2 -> 18 note cycles of C4
        write_ram(4'd0, 8'h21);
        launch(4'd0);
        play_entry("t1", 152905, 0, 18);
        expect_done("t1_end");

        // 2: tone, rest, octave-up tone
        write_ram(4'd0, 8'h11);
        write_ram(4'd1, 8'h10);
        write_ram(4'd2, 8'h18);
        launch(4'd2);
        play_entry("t2_e0", 152905, 0, 8);
        play_entry("t2_e1", 0, 1, 8);
        play_entry("t2_e2", 76452, 2, 8);
        expect_done("t2_end");

        // 3: loop back to entry 0, then finish once loop_en drops
        loop_en = 1'b1;
        launch(4'd1);
        play_entry("t3_a0", 152905, 0, 8);
        play_entry("t3_a1", 0, 1, 8);
        play_entry("t3_b0", 152905, 0, 8);
        loop_en = 1'b0;
        play_entry("t3_b1", 0, 1, 8);
        expect_done("t3_end");

        // 4: stop mid-note, then start+stop collision
        write_ram(4'd0, 8'h21);
        launch(4'd0);
        cyc("t4_load", 0, 0, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            cyc("t4_note", 152905, 0, 1);
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cyc("t4_stopped", 0, 0, 0);
            step();
        end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        cyc("t4_coll", 0, 0, 0);
        step();
        cyc("t4_coll2", 0, 0, 0);

        // 5a: dur=0 means 16 units -> 158 note cycles
        write_ram(4'd0, 8'h01);
        launch(4'd0);
        play_entry("t5_d0", 152905, 0, 158);
        expect_done("t5_d0_end");

        // 5b: restart while playing entry 1, re-latching last_idx=0
        write_ram(4'd0, 8'h11);
        write_ram(4'd1, 8'h13);
        launch(4'd1);
        play_entry("t5_r0", 152905, 0, 8);
        cyc("t5_r1_load", 0, 1, 1);
        step();
        cyc("t5_r1_note", 121359, 1, 1);
        last_idx = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        play_entry("t5_rr", 152905, 0, 8);
        expect_done("t5_r_end");

        // 5c: write to entry 0 during its LOAD plays the old data, new data next time
        launch(4'd0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h12;
        play_entry("t5_wl", 152905, 0, 8);
        expect_done("t5_wl_end");
        launch(4'd0);
        play_entry("t5_new", 136240, 0, 8);
        expect_done("t5_new_end");

        // 6: reset during the gap, RAM survives
        launch(4'd0);
        cyc("t6_load", 0, 0, 1);
        step();
        for (int i = 0; i < 8; i++) step();
        cyc("t6_gap", 0, 0, 1);
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        cyc("t6_rst", 0, 0, 0);
        step();
        cyc("t6_rst2", 0, 0, 0);
        launch(4'd0);
        play_entry("t6_replay", 136240, 0, 8);
        expect_done("t6_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
